// File: rtl/pong_pkg.sv
// Shared types and default playfield geometry for the pong controller.
// Coordinates are 9 bits wide; internal arithmetic is 10 bits.
package pong_pkg;

    localparam int COORD_W = 9;
    localparam int ARITH_W = 10;

    localparam int FIELD_W_D     = 480;
    localparam int FIELD_H_D     = 470;
    localparam int BALL_SIZE_D   = 10;
    localparam int PADDLE_W_D    = 50;
    localparam int PADDLE_Y_D    = 440;
    localparam int BALL_STEP_D   = 2;
    localparam int PADDLE_STEP_D = 4;
    localparam int BALL_Y_START  = 100;

    localparam logic [1:0] S_START    = 2'd0;
    localparam logic [1:0] S_PLAY     = 2'd1;
    localparam logic [1:0] S_GAMEOVER = 2'd2;

    typedef enum logic [1:0] {
        START    = S_START,
        PLAY     = S_PLAY,
        GAMEOVER = S_GAMEOVER
    } state_e;

    typedef enum logic {
        DIR_POS = 1'b0,
        DIR_NEG = 1'b1
    } dir_e;

endpackage

// File: rtl/pong_game_ctrl_if.sv
// Inputs and render outputs of the pong controller.
// The score signal exists only when PONG_SCORE_EN is defined.
interface pong_game_ctrl_if;

    logic       frame_tick;
    logic       btn_left;
    logic       btn_right;
    logic       btn_start;
    logic [8:0] p1_paddle_x;
    logic [8:0] p1_paddle_y;
    logic [8:0] ball_x;
    logic [8:0] ball_y;
    logic       draw_start;
    logic       draw_gameover;
`ifdef PONG_SCORE_EN
    logic [7:0] score;
`endif

    modport master (
`ifdef PONG_SCORE_EN
        input  score,
`endif
        output frame_tick, btn_left, btn_right, btn_start,
        input  p1_paddle_x, p1_paddle_y, ball_x, ball_y,
        input  draw_start, draw_gameover
    );

    modport slave (
`ifdef PONG_SCORE_EN
        output score,
`endif
        input  frame_tick, btn_left, btn_right, btn_start,
        output p1_paddle_x, p1_paddle_y, ball_x, ball_y,
        output draw_start, draw_gameover
    );

endinterface

// File: rtl/rise_detect.sv
// Registered rising-edge detector; pulse follows the level change by one cycle.
module rise_detect (
    input  logic clk,
    input  logic reset_n,
    input  logic level,
    output logic pulse
);

    logic prev;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev  <= 1'b0;
            pulse <= 1'b0;
        end else begin
            prev  <= level;
            pulse <= level & ~prev;
        end
    end

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game FSM: ball/paddle motion per frame, wall/paddle bounces, miss.
// Optional PONG_SCORE_EN adds a saturating paddle-hit score.
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int FIELD_W     = FIELD_W_D,
    parameter int FIELD_H     = FIELD_H_D,
    parameter int BALL_SIZE   = BALL_SIZE_D,
    parameter int PADDLE_W    = PADDLE_W_D,
    parameter int PADDLE_Y    = PADDLE_Y_D,
    parameter int BALL_STEP   = BALL_STEP_D,
    parameter int PADDLE_STEP = PADDLE_STEP_D
) (
    input logic             clk,
    input logic             reset_n,
    pong_game_ctrl_if.slave bus
);

    typedef logic [ARITH_W-1:0] arith_t;

    localparam arith_t W    = ARITH_W'(FIELD_W);
    localparam arith_t H    = ARITH_W'(FIELD_H);
    localparam arith_t SZ   = ARITH_W'(BALL_SIZE);
    localparam arith_t PW   = ARITH_W'(PADDLE_W);
    localparam arith_t PY   = ARITH_W'(PADDLE_Y);
    localparam arith_t BS   = ARITH_W'(BALL_STEP);
    localparam arith_t PS   = ARITH_W'(PADDLE_STEP);
    localparam arith_t PMAX = ARITH_W'(FIELD_W - PADDLE_W);
    localparam arith_t BX0  = ARITH_W'(FIELD_W / 2 - BALL_SIZE / 2);
    localparam arith_t BY0  = ARITH_W'(BALL_Y_START);
    localparam arith_t PX0  = ARITH_W'(FIELD_W / 2 - PADDLE_W / 2);

    state_e state, state_nx;
    dir_e   dx, dy, dx_nx, dy_nx;
    arith_t bx, by, px, bx_nx, by_nx, px_nx;
    logic   ds_q, dg_q;
    logic   start_rise, step, hit, miss;

    rise_detect u_rise (
        .clk     (clk),
        .reset_n (reset_n),
        .level   (bus.btn_start),
        .pulse   (start_rise)
    );

    // hit test uses the paddle position from before this frame's move
    assign step = (state == PLAY) && bus.frame_tick;
    assign hit  = (dy == DIR_POS) && (by + SZ <= PY)
               && (by + BS + SZ >= PY)
               && (bx + SZ >= px) && (bx <= px + PW);
    assign miss = (dy == DIR_POS) && (by + BS + SZ >= H) && !hit;

    always_comb begin
        state_nx = state;
        bx_nx    = bx;
        by_nx    = by;
        px_nx    = px;
        dx_nx    = dx;
        dy_nx    = dy;
        unique case (1'b1)
            state == START: begin
                if (start_rise) begin
                    state_nx = PLAY;
                    bx_nx    = BX0;
                    by_nx    = BY0;
                    px_nx    = PX0;
                    dx_nx    = DIR_POS;
                    dy_nx    = DIR_POS;
                end
            end
            state == GAMEOVER: begin
                if (start_rise) state_nx = START;
            end
            state == PLAY: begin
                if (bus.frame_tick) begin
                    if (bus.btn_left && !bus.btn_right)
                        px_nx = (px < PS) ? '0 : px - PS;
                    else if (bus.btn_right && !bus.btn_left)
                        px_nx = (px + PS > PMAX) ? PMAX : px + PS;

                    if (dx == DIR_POS) begin
                        if (bx + BS + SZ >= W) begin
                            bx_nx = W - SZ;
                            dx_nx = DIR_NEG;
                        end else begin
                            bx_nx = bx + BS;
                        end
                    end else if (bx <= BS) begin
                        bx_nx = '0;
                        dx_nx = DIR_POS;
                    end else begin
                        bx_nx = bx - BS;
                    end

                    if (dy == DIR_NEG) begin
                        if (by <= BS) begin
                            by_nx = '0;
                            dy_nx = DIR_POS;
                        end else begin
                            by_nx = by - BS;
                        end
                    end else if (hit) begin
                        by_nx = PY - SZ;
                        dy_nx = DIR_NEG;
                    end else if (miss) begin
                        by_nx    = H - SZ;
                        state_nx = GAMEOVER;
                    end else begin
                        by_nx = by + BS;
                    end
                end
            end
            default: state_nx = START;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= START;
            bx    <= BX0;
            by    <= BY0;
            px    <= PX0;
            dx    <= DIR_POS;
            dy    <= DIR_POS;
            ds_q  <= 1'b1;
            dg_q  <= 1'b0;
        end else begin
            state <= state_nx;
            bx    <= bx_nx;
            by    <= by_nx;
            px    <= px_nx;
            dx    <= dx_nx;
            dy    <= dy_nx;
            ds_q  <= (state_nx == START);
            dg_q  <= (state_nx == GAMEOVER);
        end
    end

    assign bus.p1_paddle_x   = px[COORD_W-1:0];
    assign bus.p1_paddle_y   = PY[COORD_W-1:0];
    assign bus.ball_x        = bx[COORD_W-1:0];
    assign bus.ball_y        = by[COORD_W-1:0];
    assign bus.draw_start    = ds_q;
    assign bus.draw_gameover = dg_q;

`ifdef PONG_SCORE_EN
    logic [7:0] score_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            score_q <= '0;
        else if (state == START && start_rise)
            score_q <= '0;
        else if (step && hit && score_q != 8'hff)
            score_q <= score_q + 8'd1;
    end

    assign bus.score = score_q;
`endif

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Randomised scoreboard bench for pong_game_ctrl against a frame-level model.
// Define PONG_SCORE_EN to also check the score output.
`timescale 1ns/1ps
module tb_pong_game_ctrl;

    localparam int W  = 480;
    localparam int H  = 470;
    localparam int SZ = 10;
    localparam int PW = 50;
    localparam int PY = 440;
    localparam int BS = 2;
    localparam int PS = 4;

    typedef struct packed {
        logic [8:0] px;
        logic [8:0] py;
        logic [8:0] bx;
        logic [8:0] by;
        logic       ds;
        logic       dg;
        logic [7:0] sc;
        logic [1:0] kind;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];

    // model: mode 0=start 1=play 2=gameover, velocities in px/frame
    int m_mode, m_bx, m_by, m_vx, m_vy, m_px, m_sc;

    pong_game_ctrl_if bus();

    pong_game_ctrl dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    function automatic string kname(input logic [1:0] k);
        case (k)
            2'd0:    return "reset";
            2'd1:    return "frame";
            default: return "start_btn";
        endcase
    endfunction

    task automatic push(input logic [1:0] k);
        exp_t e;
        e.px   = 9'(m_px);
        e.py   = 9'(PY);
        e.bx   = 9'(m_bx);
        e.by   = 9'(m_by);
        e.ds   = (m_mode == 0);
        e.dg   = (m_mode == 2);
        e.sc   = 8'(m_sc);
        e.kind = k;
        q.push_back(e);
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_bx   = W / 2 - SZ / 2;
        m_by   = 100;
        m_px   = W / 2 - PW / 2;
        m_vx   = BS;
        m_vy   = BS;
        m_sc   = 0;
    endtask

    task automatic model_start();
        if (m_mode == 0) begin
            model_reset();
            m_mode = 1;
        end else if (m_mode == 2) begin
            m_mode = 0;
        end
    endtask

    task automatic model_frame(input bit l, input bit r);
        int  nbx, nby, npx;
        bit  hit;
        if (m_mode != 1) return;
        hit = (m_vy > 0) && (m_by + SZ <= PY) && (m_by + SZ + BS >= PY)
           && (m_bx + SZ >= m_px) && (m_bx <= m_px + PW);
        nbx = m_bx + m_vx;
        if (nbx + SZ >= W) begin
            nbx  = W - SZ;
            m_vx = -BS;
        end else if (nbx <= 0) begin
            nbx  = 0;
            m_vx = BS;
        end
        nby = m_by + m_vy;
        if (hit) begin
            nby  = PY - SZ;
            m_vy = -BS;
            if (m_sc < 255) m_sc++;
        end else if (nby + SZ >= H) begin
            nby    = H - SZ;
            m_mode = 2;
        end else if (nby <= 0) begin
            nby  = 0;
            m_vy = BS;
        end
        if (l != r) begin
            npx  = r ? m_px + PS : m_px - PS;
            m_px = (npx < 0) ? 0 : (npx > W - PW) ? W - PW : npx;
        end
        m_bx = nbx;
        m_by = nby;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() > 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations pending, want 0", q.size());
            q.delete();
        end
    endtask

    task automatic tick(input bit l, input bit r);
        @(posedge clk);
        #1;
        bus.btn_left   = l;
        bus.btn_right  = r;
        bus.frame_tick = 1'b1;
        @(posedge clk);
        #1;
        bus.frame_tick = 1'b0;
        model_frame(l, r);
        push(2'd1);
        drain();
    endtask

    task automatic press_start();
        @(posedge clk);
        #1;
        bus.btn_start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        bus.btn_start = 1'b0;
        repeat (3) @(posedge clk);
        model_start();
        push(2'd2);
        drain();
    endtask

    // reset values must be visible at the negedge before the next clk edge
    task automatic do_reset();
        @(posedge clk);
        #1;
        bus.btn_start  = 1'b0;
        bus.frame_tick = 1'b0;
        reset_n        = 1'b0;
        model_reset();
        push(2'd0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        drain();
    endtask

    initial begin : monitor
        exp_t  e;
        logic  ok;
        string got, want;
        forever begin
            @(negedge clk);
            while (q.size() > 0) begin
                e  = q.pop_front();
                ok = (bus.p1_paddle_x == e.px) && (bus.p1_paddle_y == e.py)
                  && (bus.ball_x == e.bx) && (bus.ball_y == e.by)
                  && (bus.draw_start == e.ds)
                  && (bus.draw_gameover == e.dg);
                got = $sformatf("px=%0d py=%0d bx=%0d by=%0d ds=%0b dg=%0b",
                    bus.p1_paddle_x, bus.p1_paddle_y, bus.ball_x,
                    bus.ball_y, bus.draw_start, bus.draw_gameover);
                want = $sformatf("px=%0d py=%0d bx=%0d by=%0d ds=%0b dg=%0b",
                    e.px, e.py, e.bx, e.by, e.ds, e.dg);
`ifdef PONG_SCORE_EN
                ok   = ok && (bus.score == e.sc);
                got  = {got, $sformatf(" sc=%0d", bus.score)};
                want = {want, $sformatf(" sc=%0d", e.sc)};
`endif
                checks++;
                if (!ok) begin
                    errors++;
                    $display("FAIL %s: got %s want %s", kname(e.kind), got, want);
                end
            end
        end
    end

    initial begin : stim
        int frames;
        int tgt;
        int steer_off;
        bit l, r;
        bus.frame_tick = 1'b0;
        bus.btn_left   = 1'b0;
        bus.btn_right  = 1'b0;
        bus.btn_start  = 1'b0;
        steer_off      = 0;

        do_reset();
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        press_start();
        tick(1'b0, 1'b0);
        repeat (3) tick(1'b1, 1'b1);
        repeat (56) tick(1'b1, 1'b0);
        repeat (110) tick(1'b0, 1'b1);

        frames = 0;
        while (frames < 2600) begin
            if (m_mode == 2) begin
                tick(1'b0, 1'b0);
                tick(1'b1, 1'b0);
                press_start();
                press_start();
            end else if (m_mode == 0) begin
                press_start();
            end else begin
                if (frames == 1200) begin
                    do_reset();
                end else begin
                    if (frames % 16 == 0)
                        steer_off = int'($urandom_range(0, 64)) - 32;
                    if ($urandom_range(0, 3) != 0) begin
                        tgt = m_bx + SZ / 2 - PW / 2 + steer_off;
                        l   = (m_px > tgt + 2);
                        r   = (m_px + 2 < tgt);
                    end else begin
                        l = 1'($urandom_range(0, 1));
                        r = 1'($urandom_range(0, 1));
                    end
                    tick(l, r);
                    if ($urandom_range(0, 49) == 0) press_start();
                end
                frames++;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pong_game_ctrl.md
PONG_GAME_CTRL -- requirements
Module: pong_game_ctrl

Interface
REQ-001 The parameter FIELD_W SHALL default to 480 and sets the playfield width in pixels.
REQ-002 The parameter FIELD_H SHALL default to 470 and sets the playfield height in pixels.
REQ-003 The parameter BALL_SIZE SHALL default to 10 and sets the ball edge length.
REQ-004 The parameter PADDLE_W SHALL default to 50 and sets the paddle width.
REQ-005 The parameter PADDLE_Y SHALL default to 440 and sets the fixed paddle top row.
REQ-006 The parameter BALL_STEP SHALL default to 2 and sets the ball pixels per frame, per axis.
REQ-007 The parameter PADDLE_STEP SHALL default to 4 and sets the paddle pixels per frame.
REQ-008 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-009 The port clk SHALL be an input, 1 bit wide, and is the system pixel clock.
REQ-010 The port reset_n SHALL be an input, 1 bit wide, and is the asynchronous active-low reset.
REQ-011 The port frame_tick SHALL be an input, 1 bit wide, and is a one-cycle pulse per video frame (vertical blank).
REQ-012 The port btn_left SHALL be an input, 1 bit wide, and is the synchronised level for moving the paddle left.
REQ-013 The port btn_right SHALL be an input, 1 bit wide, and is the synchronised level for moving the paddle right.
REQ-014 The port btn_start SHALL be an input, 1 bit wide, and is the synchronised start/restart level.
REQ-015 The ports p1_paddle_x and p1_paddle_y SHALL be outputs, 9 bits each, and give the paddle top-left corner.
REQ-016 The ports ball_x and ball_y SHALL be outputs, 9 bits each, and give the ball top-left corner.
REQ-017 The ports draw_start and draw_gameover SHALL be outputs, 1 bit each, and select the renderer's full-screen modes.

Function
REQ-018 The FSM SHALL have exactly three states: START, PLAY and GAMEOVER. draw_start SHALL be 1 only in START, and draw_gameover SHALL be 1 only in GAMEOVER.
REQ-019 A rising edge of btn_start, detected one cycle after the level changes, SHALL move START to PLAY and GAMEOVER to START. btn_start SHALL be ignored while in PLAY.
REQ-020 Entering PLAY SHALL load ball=(FIELD_W/2-BALL_SIZE/2, 100) and paddle_x=FIELD_W/2-PADDLE_W/2, and set the direction to dx=+ and dy=+.
REQ-021 Positions SHALL update only on cycles where frame_tick=1 and state=PLAY; otherwise all outputs SHALL hold their values.
REQ-022 If btn_start triggers a transition on the same cycle as frame_tick, the transition SHALL win and no motion SHALL occur that cycle.
REQ-023 Paddle: btn_left alone SHALL give x-PADDLE_STEP, clamped at 0. btn_right alone SHALL give x+PADDLE_STEP, clamped at FIELD_W-PADDLE_W. Both pressed or neither SHALL give no move.
REQ-024 Horizontal wall: if dx=+ and ball_x+BALL_STEP+BALL_SIZE>=FIELD_W, then ball_x=FIELD_W-BALL_SIZE and dx flips to -. If dx=- and ball_x<=BALL_STEP, then ball_x=0 and dx flips to +.
REQ-025 Top wall: if dy=- and ball_y<=BALL_STEP, then ball_y=0 and dy flips to +.
REQ-026 Paddle hit: if dy=+, ball_y+BALL_SIZE<=PADDLE_Y, ball_y+BALL_STEP+BALL_SIZE>=PADDLE_Y, ball_x+BALL_SIZE>=paddle_x and ball_x<=paddle_x+PADDLE_W, then ball_y=PADDLE_Y-BALL_SIZE and dy flips to -.
REQ-027 Miss: if dy=+ and ball_y+BALL_STEP+BALL_SIZE>=FIELD_H without a paddle hit, then ball_y=FIELD_H-BALL_SIZE and the next state SHALL be GAMEOVER.
REQ-028 The x and y axes SHALL resolve independently in the same frame, so a corner bounce flips both directions.
REQ-029 The paddle and the ball SHALL update in the same frame_tick cycle, and the paddle-hit test SHALL use the pre-update paddle_x.
REQ-030 All arithmetic SHALL be done at 10-bit width to prevent 9-bit wrap, and all outputs SHALL be registered with 1-cycle latency from frame_tick.

Reset
REQ-031 Asserting reset_n=0 SHALL immediately force: state=START, ball=(235,100), p1_paddle_x=215, p1_paddle_y=PADDLE_Y, dx=+, dy=+, draw_start=1, draw_gameover=0, and the btn_start edge register=0.
REQ-032 A reset asserted mid-PLAY SHALL abandon the game with no GAMEOVER state shown.

Configuration
REQ-033 When PONG_SCORE_EN is defined, the block SHALL add the output score (8 bits). score SHALL increment on each paddle hit, saturate at 255, clear on entering PLAY, and reset to 0.
REQ-034 When PONG_SCORE_EN is undefined, the score port and its logic SHALL be absent, and all other behaviour SHALL be unchanged.

Structure
REQ-035 The package pong_pkg SHALL hold the state enum (START/PLAY/GAMEOVER), the direction typedef and the default field constants.
REQ-036 The sub-module rise_detect SHALL provide the btn_start rising-edge pulse.

Verification
REQ-037 Start sequence: reset, then a btn_start pulse, then one frame_tick → state PLAY, draw_start=0, and ball=(237,102).
REQ-038 Right wall: ball_x=469 with dx=+, then frame_tick → ball_x=470 and dx=-.
REQ-039 Paddle hit: paddle_x=215, ball=(230,429) with dy=+, then frame_tick → ball_y=430 and dy=-; with PONG_SCORE_EN, score increments by 1.
REQ-040 Miss: paddle_x=0, ball=(300,459) with dy=+, then frame_tick → ball_y=460, draw_gameover=1, and the ball holds on later ticks.
REQ-041 Paddle clamp: paddle_x=2 with btn_left held, then frame_tick → 0. Both buttons held → no change. paddle_x=428 with btn_right → 430.
REQ-042 Reset mid-PLAY: assert reset_n=0 → all reset values are present before the next clk edge.
